// File: rtl/avr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avr_pkg
// Purpose  : Shared types and default thresholds for the averaging chain.
// Revision : 1.0 - initial release
// ============================================================================
package avr_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } avr_hyst_state_t;

    localparam int AVR_WIDTH_DEFAULT = 8;
    localparam int AVR_TH_HI_DEFAULT = 192;
    localparam int AVR_TH_LO_DEFAULT = 64;
    localparam int AVR_HOLD_DEFAULT  = 3;
    localparam int AVR_CNT_W_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sat_cnt
// Purpose  : Up-counter that sticks at all-ones; synchronous clear wins.
// Revision : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/avr_hyst_det.sv
`default_nettype none
// ============================================================================
// Module   : avr_hyst_det
// Purpose  : Two-threshold hysteresis detector with hold qualifier, edge
//            pulses and a saturating transition count.
// Revision : 1.0 - initial release
// ============================================================================
module avr_hyst_det
    import avr_pkg::*;
#(
    parameter int WIDTH = AVR_WIDTH_DEFAULT,
    parameter int TH_HI = AVR_TH_HI_DEFAULT,
    parameter int TH_LO = AVR_TH_LO_DEFAULT,
    parameter int HOLD  = AVR_HOLD_DEFAULT,
    parameter int CNT_W = AVR_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] avr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int              HCW     = $clog2(HOLD + 1);
    localparam logic [WIDTH-1:0] C_TH_HI = WIDTH'(TH_HI);
    localparam logic [WIDTH-1:0] C_TH_LO = WIDTH'(TH_LO);
    localparam logic [HCW-1:0]   C_HOLD  = HCW'(HOLD);

    if (!((TH_LO < TH_HI) && (longint'(TH_HI) < (longint'(1) << WIDTH)) && (HOLD >= 1)))
    begin : g_param_check
        $error("avr_hyst_det: require TH_LO < TH_HI < 2**WIDTH and HOLD >= 1");
    end

    avr_hyst_state_t r_state, w_state_nxt;
    logic [HCW-1:0]  r_hcnt, w_hcnt_nxt, w_hcnt_inc;
    logic            r_level, r_rise, r_fall;
    logic            w_rise_nxt, w_fall_nxt;
    logic            w_q_hi, w_q_lo;

    assign w_q_hi     = (avr >= C_TH_HI);
    assign w_q_lo     = (avr <= C_TH_LO);
    assign w_hcnt_inc = r_hcnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                S_LOW: begin
                    if (w_q_hi) begin
                        if (HOLD == 1) begin
                            w_state_nxt = S_HIGH;
                            w_rise_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_RISE_CHK;
                            w_hcnt_nxt  = HCW'(1);
                        end
                    end
                end
                S_RISE_CHK: begin
                    if (!w_q_hi) begin
                        w_state_nxt = S_LOW;
                        w_hcnt_nxt  = '0;
                    end else if (w_hcnt_inc == C_HOLD) begin
                        w_state_nxt = S_HIGH;
                        w_hcnt_nxt  = '0;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc;
                    end
                end
                S_HIGH: begin
                    if (w_q_lo) begin
                        if (HOLD == 1) begin
                            w_state_nxt = S_LOW;
                            w_fall_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_FALL_CHK;
                            w_hcnt_nxt  = HCW'(1);
                        end
                    end
                end
                S_FALL_CHK: begin
                    if (!w_q_lo) begin
                        w_state_nxt = S_HIGH;
                        w_hcnt_nxt  = '0;
                    end else if (w_hcnt_inc == C_HOLD) begin
                        w_state_nxt = S_LOW;
                        w_hcnt_nxt  = '0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_LOW;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Level is registered from the next state so it moves on the same edge as the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
            r_hcnt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else if (clr) begin
            r_state <= S_LOW;
            r_hcnt  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_level <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALL_CHK);
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    sat_cnt #(
        .W(CNT_W)
    ) u_edge_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (w_rise_nxt | w_fall_nxt),
        .q    (edge_cnt)
    );

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_avr_hyst_det.sv
`default_nettype none
// ============================================================================
// Module   : tb_avr_hyst_det
// Purpose  : Vector table plus corner sequences, checked through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avr_hyst_det;
    import avr_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] avr;
        logic       level;
        logic       rise;
        logic       fall;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        int         id;
        logic       level;
        logic       rise;
        logic       fall;
        logic [3:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             en;
    logic [7:0]       avr;
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;

    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;
    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;

    avr_hyst_det #(
        .WIDTH(AVR_WIDTH_DEFAULT),
        .TH_HI(AVR_TH_HI_DEFAULT),
        .TH_LO(AVR_TH_LO_DEFAULT),
        .HOLD (AVR_HOLD_DEFAULT),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (en),
        .avr     (avr),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .edge_cnt(edge_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic r,
                           input logic f, input logic [3:0] n);
        chk({tag, " level"},    int'(level),    int'(l));
        chk({tag, " rise"},     int'(rise),     int'(r));
        chk({tag, " fall"},     int'(fall),     int'(f));
        chk({tag, " edge_cnt"}, int'(edge_cnt), int'(n));
    endtask

    task automatic add(input logic e, input logic c, input logic [7:0] a,
                       input logic l, input logic r, input logic f, input logic [3:0] n);
        vecs.push_back('{e, c, a, l, r, f, n});
    endtask

    // Drive one sample at the falling edge; its expectation is checked after the next rising edge.
    task automatic drive(input logic e, input logic c, input logic [7:0] a,
                         input logic l, input logic r, input logic f, input logic [3:0] n);
        @(negedge clk);
        en  = e;
        clr = c;
        avr = a;
        step_id++;
        sb.push_back('{step_id, l, r, f, n});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk_all($sformatf("step%0d", cur.id), cur.level, cur.rise, cur.fall, cur.cnt);
        end
    end

    task automatic drain();
        @(posedge clk);
        #2;
        chk("scoreboard drained", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        avr   = 8'd0;

        // Clean rise / clean fall
        add(1, 0, 200, 0, 0, 0, 0); add(1, 0, 200, 0, 0, 0, 0);
        add(1, 0, 200, 1, 1, 0, 1); add(1, 0, 200, 1, 0, 0, 1);
        add(1, 0,  10, 1, 0, 0, 1); add(1, 0,  10, 1, 0, 0, 1);
        add(1, 0,  10, 0, 0, 1, 2); add(1, 0,  10, 0, 0, 0, 2);
        // Aborted rise
        add(1, 0, 200, 0, 0, 0, 2); add(1, 0, 200, 0, 0, 0, 2);
        add(1, 0, 128, 0, 0, 0, 2); add(1, 0, 200, 0, 0, 0, 2);
        add(1, 0, 200, 0, 0, 0, 2); add(1, 0, 200, 1, 1, 0, 3);
        // Fall threshold boundary: 64 qualifies, 65 aborts
        add(1, 0,  64, 1, 0, 0, 3); add(1, 0,  65, 1, 0, 0, 3);
        add(1, 0,  64, 1, 0, 0, 3); add(1, 0,  64, 1, 0, 0, 3);
        add(1, 0,  64, 0, 0, 1, 4);
        // Rise threshold boundary: 192 qualifies, 191 aborts
        add(1, 0, 192, 0, 0, 0, 4); add(1, 0, 191, 0, 0, 0, 4);
        add(1, 0, 192, 0, 0, 0, 4); add(1, 0, 192, 0, 0, 0, 4);
        add(1, 0, 192, 1, 1, 0, 5);
        add(1, 0,   0, 1, 0, 0, 5); add(1, 0,   0, 1, 0, 0, 5);
        add(1, 0,   0, 0, 0, 1, 6);
        // Gapped en
        add(1, 0, 200, 0, 0, 0, 6); add(0, 0, 200, 0, 0, 0, 6);
        add(0, 0, 200, 0, 0, 0, 6); add(1, 0, 200, 0, 0, 0, 6);
        add(0, 0, 200, 0, 0, 0, 6); add(1, 0, 200, 1, 1, 0, 7);
        add(0, 0, 200, 1, 0, 0, 7); add(0, 0,   0, 1, 0, 0, 7);
        // clr together with en at level 1: no fall, sample discarded
        add(1, 1,   0, 0, 0, 0, 0); add(1, 0, 200, 0, 0, 0, 0);
        add(1, 0, 200, 0, 0, 0, 0); add(1, 0, 200, 1, 1, 0, 1);

        // Reset state
        @(posedge clk); #1;
        chk_all("in_reset_a", 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("in_reset_b", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 200, 0, 0, 0, 0);

        foreach (vecs[i])
            drive(vecs[i].en, vecs[i].clr, vecs[i].avr,
                  vecs[i].level, vecs[i].rise, vecs[i].fall, vecs[i].cnt);

        // Dead band held at level 1
        for (int i = 0; i < 20; i++)
            drive(1, 0, 100, 1, 0, 0, 1);

        // Saturation over 20 alternating transitions
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            logic [7:0] a;
            logic       lv;
            logic [3:0] prev;
            logic [3:0] nxt;
            a    = (k % 2 == 1) ? 8'd200 : 8'd0;
            lv   = (k % 2 == 1);
            prev = 4'((k - 1 > 15) ? 15 : k - 1);
            nxt  = 4'((k > 15) ? 15 : k);
            drive(1, 0, a, ~lv, 0, 0, prev);
            drive(1, 0, a, ~lv, 0, 0, prev);
            drive(1, 0, a, lv, lv, ~lv, nxt);
        end

        // rst_n during a pending rise check
        drive(1, 0, 200, 0, 0, 0, 15);
        drive(1, 0, 200, 0, 0, 0, 15);
        drain();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("reset_hold", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 200, 0, 0, 0, 0);
        drive(1, 0, 200, 0, 0, 0, 0);
        drive(1, 0, 200, 1, 1, 0, 1);

        // clr during a pending fall at level 1
        drive(1, 0,   0, 1, 0, 0, 1);
        drive(0, 1,   0, 0, 0, 0, 0);
        drive(1, 0,   0, 0, 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avr_hyst_det.md
# avr_hyst_det

Hysteresis threshold detector that sits directly downstream of the moving-average filter and consumes its averaged sample stream. It converts the noisy multi-bit average into a clean binary level using two thresholds plus a consecutive-sample hold qualifier, and emits single-cycle rise/fall pulses and a saturating transition count. All outputs are registered. The block is intended to feed edge-driven control logic without further glitch filtering.

## Interface
- WIDTH, 8: width of the averaged sample `avr`.
- TH_HI, 192: rise threshold; a sample qualifies high when `avr >= TH_HI`.
- TH_LO, 64: fall threshold; a sample qualifies low when `avr <= TH_LO`.
- HOLD, 3: number of consecutive qualifying samples required to change level.
- CNT_W, 16: width of the transition counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- clr  in  1  synchronous clear; has priority over `en`.
- en  in  1  sample strobe; `avr` is valid and consumed only when `en=1`.
- avr  in  WIDTH  averaged sample from the moving-average filter, unsigned.
- level  out  1  debounced level.
- rise  out  1  one-cycle pulse on a 0->1 level change.
- fall  out  1  one-cycle pulse on a 1->0 level change.
- edge_cnt  out  CNT_W  count of level changes (rise+fall), saturating.

## Operation
- Elaboration error unless TH_LO < TH_HI < 2**WIDTH and HOLD >= 1.
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK. Internal hold counter `hcnt` is ceil(log2(HOLD+1)) bits wide.
- Cycles with `en=0`: state and `hcnt` hold; `rise` and `fall` are 0.
- S_LOW, en:
  - If the sample qualifies high and HOLD==1: go to S_HIGH.
  - If the sample qualifies high and HOLD>1: go to S_RISE_CHK with hcnt=1.
  - Otherwise stay in S_LOW.
- S_RISE_CHK, en:
  - If the sample qualifies high: hcnt+1. When hcnt+1==HOLD, go to S_HIGH and clear hcnt.
  - If the sample does not qualify: go to S_LOW with hcnt=0.
- S_HIGH and S_FALL_CHK mirror S_LOW and S_RISE_CHK, using the low qualification (`avr <= TH_LO`).
- Samples strictly between TH_LO and TH_HI never qualify. They abort a pending check and leave a settled state unchanged.
- `level` = 1 in S_HIGH and S_FALL_CHK, 0 otherwise.
- Entering S_HIGH from S_LOW or S_RISE_CHK registers `rise`=1 and increments `edge_cnt`. Entering S_LOW from S_FALL_CHK registers `fall`=1 and increments `edge_cnt`.
- `edge_cnt` saturates at 2**CNT_W-1 and does not wrap.
- `clr`=1: next state S_LOW, hcnt=0, level=0, edge_cnt=0, rise=fall=0. No `fall` pulse is generated, even when level was 1.

## Timing
- Reset values: level=0, rise=0, fall=0, edge_cnt=0, state S_LOW, hcnt=0.
- Latency: the HOLD-th qualifying sample, sampled at edge N, drives `level`, `rise`/`fall` and `edge_cnt` valid after edge N. This is one cycle after that sample is presented.
- `rise`/`fall` are high for exactly one clk, even if `en` stays high. They are never high simultaneously.
- Qualifying samples need not be on adjacent clocks; only `en` cycles count.
- `rst_n` asserted mid-check: immediate return to reset values, no pulse.
- `clr` and `en` in the same cycle: `clr` wins and the sample is discarded.

## Structure
- Shared package `avr_pkg`:
  - state enum typedef `avr_hyst_state_t`;
  - default threshold localparams, reused by the filter's bench.
- One sub-module, `sat_cnt` (parameter W; ports clk, rst_n, clr, inc, q), implements the saturating `edge_cnt`. The FSM and hold counter stay in `avr_hyst_det`.

## Test plan
All scenarios use WIDTH=8, TH_HI=192, TH_LO=64, HOLD=3, CNT_W=4, with `en` high every cycle unless stated.
- Reset: during and after reset, level=0, rise=fall=0, edge_cnt=0.
- Clean rise: avr=200 for 3 en cycles -> level=1 and rise=1 for one clk after the 3rd sampling edge; edge_cnt=1.
- Aborted rise: samples 200, 200, 128, 200, 200 -> no rise. Level first goes 1 after a further (3rd consecutive) 200.
- Gapped `en`: 200 with en pattern 1,0,0,1,0,1 -> rise after the 3rd en-qualified sample. Dead band: 100 held for 20 cycles at level 1 -> level stays 1, no fall.
- Saturation: 20 alternating rise/fall sequences -> edge_cnt stops at 15.
- Clear/reset mid-operation: `clr` while level=1 -> level=0, edge_cnt=0, no fall pulse. `rst_n` low during S_RISE_CHK -> reset values, no rise.
